// File: rtl/ex_stage_pkg.sv
// Shared CPU definitions used by the execute stage: ALU opcodes, EX FSM states
// and the iterative multiplier sizing.
package ex_stage_pkg;

   typedef enum logic [3:0] {
      ALU_ADD  = 4'd0,
      ALU_SUB  = 4'd1,
      ALU_AND  = 4'd2,
      ALU_OR   = 4'd3,
      ALU_XOR  = 4'd4,
      ALU_NOR  = 4'd5,
      ALU_SLT  = 4'd6,
      ALU_SLTU = 4'd7,
      ALU_SLL  = 4'd8,
      ALU_SRL  = 4'd9,
      ALU_SRA  = 4'd10,
      ALU_MUL  = 4'd11,
      ALU_LUI  = 4'd12
   } alu_op_e;

   typedef enum logic [1:0] {
      EX_IDLE = 2'd0,
      EX_MUL  = 2'd1,
      EX_DONE = 2'd2
   } ex_state_e;

   localparam int unsigned MUL_ITERS = 32;
   localparam int unsigned MUL_CNT_W = $clog2(MUL_ITERS);

   typedef struct packed {
      logic reg_write;
      logic mem_to_reg;
      logic mem_wen;
      logic mem_ren;
   } ctl_t;

endpackage

// File: rtl/ex_stage_mul_iter.sv
// Iterative shift-add multiplier: one multiplier bit per cycle, low 32 product bits.
// done pulses during the final iteration; product is valid the cycle after.
module mul_iter
   import ex_stage_pkg::*;
(
   input  logic        clock,
   input  logic        reset,
   input  logic        start,
   input  logic        abort,
   input  logic [31:0] multiplicand,
   input  logic [31:0] multiplier,
   output logic        done,
   output logic [31:0] product
);

   localparam logic [MUL_CNT_W-1:0] LAST_CNT = MUL_CNT_W'(MUL_ITERS - 1);

   logic [31:0]          mcand;
   logic [31:0]          mplier;
   logic [31:0]          acc;
   logic [MUL_CNT_W-1:0] count;
   logic                 running;

   always_ff @(posedge clock) begin
      if (reset) begin
         mcand   <= '0;
         mplier  <= '0;
         acc     <= '0;
         count   <= '0;
         running <= 1'b0;
      end else if (abort) begin
         count   <= '0;
         running <= 1'b0;
      end else if (start) begin
         mcand   <= multiplicand;
         mplier  <= multiplier;
         acc     <= '0;
         count   <= '0;
         running <= 1'b1;
      end else if (running) begin
         // bits shifted past bit 31 only affect the discarded high product half
         if (mplier[0])
            acc <= acc + mcand;
         mcand  <= mcand << 1;
         mplier <= mplier >> 1;
         count  <= count + 1'b1;
         if (count == LAST_CNT)
            running <= 1'b0;
      end
   end

   assign done    = running && (count == LAST_CNT);
   assign product = acc;

endmodule

// File: rtl/ex_stage.sv
// Execute stage: operand forwarding, single-cycle ALU, multi-cycle multiply
// with pipeline stall, and the EX/MEM pipeline register.
module ex_stage
   import ex_stage_pkg::*;
(
   input  logic        clock,
   input  logic        reset,
   input  logic [3:0]  EX_ALUOp,
   input  logic [31:0] EX_D1,
   input  logic [31:0] EX_D2,
   input  logic [31:0] EX_IMM,
   input  logic [4:0]  EX_RS,
   input  logic [4:0]  EX_RT,
   input  logic [4:0]  EX_RD,
   input  logic [4:0]  EX_SHAMT,
   input  logic        EX_shift,
   input  logic        EX_ALUSrc,
   input  logic        EX_RegDst,
   input  logic        EX_RegWrite,
   input  logic        EX_MemToReg,
   input  logic        EX_MEM_WEN,
   input  logic        EX_MEM_REN,
   input  logic        WB_RegWrite,
   input  logic [4:0]  WB_WR_REG,
   input  logic [31:0] WB_DATA,
   input  logic        ex_flush,
   output logic [31:0] MEM_ALU_RESULT,
   output logic [31:0] MEM_D2,
   output logic [4:0]  MEM_WR_REG,
   output logic        MEM_RegWrite,
   output logic        MEM_MemToReg,
   output logic        MEM_MEM_WEN,
   output logic        MEM_MEM_REN,
   output logic        ex_stall
);

   ex_state_e   state, state_nxt;
   alu_op_e     op;
   logic [31:0] fwd_a, fwd_b, op_b, alu_res, mul_product;
   logic [4:0]  shamt, dest;
   ctl_t        in_ctl, lat_ctl, ctl_nxt;
   logic [4:0]  lat_dest, wr_nxt;
   logic [31:0] lat_b, res_nxt, d2_nxt;
   logic        is_mul, mul_start, mul_done;

   assign op     = alu_op_e'(EX_ALUOp);
   assign is_mul = (op == ALU_MUL);
   assign in_ctl = {EX_RegWrite, EX_MemToReg, EX_MEM_WEN, EX_MEM_REN};

   // MEM-stage result is younger than WB, so it is checked first
   always_comb begin
      fwd_a = EX_D1;
      if (MEM_RegWrite && (MEM_WR_REG != '0) && (MEM_WR_REG == EX_RS))
         fwd_a = MEM_ALU_RESULT;
      else if (WB_RegWrite && (WB_WR_REG != '0) && (WB_WR_REG == EX_RS))
         fwd_a = WB_DATA;

      fwd_b = EX_D2;
      if (MEM_RegWrite && (MEM_WR_REG != '0) && (MEM_WR_REG == EX_RT))
         fwd_b = MEM_ALU_RESULT;
      else if (WB_RegWrite && (WB_WR_REG != '0) && (WB_WR_REG == EX_RT))
         fwd_b = WB_DATA;
   end

   assign op_b  = EX_ALUSrc ? EX_IMM : fwd_b;
   assign shamt = EX_shift ? EX_SHAMT : op_b[4:0];
   assign dest  = EX_RegDst ? EX_RD : EX_RT;

   always_comb begin
      alu_res = '0;
      case (op)
         ALU_ADD:  alu_res = fwd_a + op_b;
         ALU_SUB:  alu_res = fwd_a - op_b;
         ALU_AND:  alu_res = fwd_a & op_b;
         ALU_OR:   alu_res = fwd_a | op_b;
         ALU_XOR:  alu_res = fwd_a ^ op_b;
         ALU_NOR:  alu_res = ~(fwd_a | op_b);
         ALU_SLT:  alu_res = {31'b0, $signed(fwd_a) < $signed(op_b)};
         ALU_SLTU: alu_res = {31'b0, fwd_a < op_b};
         ALU_SLL:  alu_res = op_b << shamt;
         ALU_SRL:  alu_res = op_b >> shamt;
         ALU_SRA:  alu_res = 32'($signed(op_b) >>> shamt);
         ALU_LUI:  alu_res = op_b << 16;
         default:  alu_res = '0;
      endcase
   end

   mul_iter u_mul_iter (
      .clock        (clock),
      .reset        (reset),
      .start        (mul_start),
      .abort        (ex_flush),
      .multiplicand (fwd_a),
      .multiplier   (fwd_b),
      .done         (mul_done),
      .product      (mul_product)
   );

   // next EX/MEM contents default to a zeroed bubble
   always_comb begin
      state_nxt = state;
      ex_stall  = 1'b0;
      mul_start = 1'b0;
      res_nxt   = '0;
      d2_nxt    = '0;
      wr_nxt    = '0;
      ctl_nxt   = '0;
      if (ex_flush) begin
         state_nxt = EX_IDLE;
      end else begin
         case (state)
            EX_IDLE: begin
               if (is_mul) begin
                  mul_start = 1'b1;
                  ex_stall  = 1'b1;
                  state_nxt = EX_MUL;
               end else begin
                  res_nxt = alu_res;
                  d2_nxt  = fwd_b;
                  wr_nxt  = dest;
                  ctl_nxt = in_ctl;
               end
            end
            EX_MUL: begin
               ex_stall = 1'b1;
               if (mul_done)
                  state_nxt = EX_DONE;
            end
            EX_DONE: begin
               res_nxt   = mul_product;
               d2_nxt    = lat_b;
               wr_nxt    = lat_dest;
               ctl_nxt   = lat_ctl;
               state_nxt = EX_IDLE;
            end
            default: state_nxt = EX_IDLE;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state          <= EX_IDLE;
         lat_ctl        <= '0;
         lat_dest       <= '0;
         lat_b          <= '0;
         MEM_ALU_RESULT <= '0;
         MEM_D2         <= '0;
         MEM_WR_REG     <= '0;
         MEM_RegWrite   <= 1'b0;
         MEM_MemToReg   <= 1'b0;
         MEM_MEM_WEN    <= 1'b0;
         MEM_MEM_REN    <= 1'b0;
      end else begin
         state <= state_nxt;
         if (mul_start) begin
            lat_ctl  <= in_ctl;
            lat_dest <= dest;
            lat_b    <= fwd_b;
         end
         MEM_ALU_RESULT <= res_nxt;
         MEM_D2         <= d2_nxt;
         MEM_WR_REG     <= wr_nxt;
         MEM_RegWrite   <= ctl_nxt.reg_write;
         MEM_MemToReg   <= ctl_nxt.mem_to_reg;
         MEM_MEM_WEN    <= ctl_nxt.mem_wen;
         MEM_MEM_REN    <= ctl_nxt.mem_ren;
      end
   end

endmodule
